seq_issue: RTL and testbench

//  Instruction buffer and issue controller in front of the seq datapath (rf + alu + send).

---
 rtl/seq_issue_pkg.sv | 55 +++++
 rtl/seq_issue_fifo.sv | 72 +++++++
 rtl/seq_issue.sv | 102 ++++++++++
 tb/tb_seq_issue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_issue_pkg.sv
// Shared instruction encoding for the seq datapath and its issue controller.
// Field layout: op in the top bits, then ra, rb, rc; push carries an immediate in the rb/rc bits.
package seq_issue_pkg;

  localparam int seq_op_width = 2;
  localparam int seq_rn_width = 4;
  localparam int seq_in_width = seq_op_width + 3 * seq_rn_width;
  localparam int seq_nregs    = 1 << seq_rn_width;

  localparam logic [seq_op_width-1:0] seq_op_push = 2'd0;
  localparam logic [seq_op_width-1:0] seq_op_add  = 2'd1;
  localparam logic [seq_op_width-1:0] seq_op_mult = 2'd2;
  localparam logic [seq_op_width-1:0] seq_op_send = 2'd3;

  typedef logic [seq_rn_width-1:0] seq_reg_t;

  typedef struct packed {
    logic     rd_a;
    logic     rd_b;
    logic     wr;
    logic     is_send;
    seq_reg_t ra;
    seq_reg_t rb;
    seq_reg_t wreg;
  } seq_dec_t;

  function automatic seq_dec_t seq_decode(input logic [seq_in_width-1:0] inst);
    seq_dec_t                d;
    logic [seq_op_width-1:0] op;
    op        = inst[seq_in_width-1 -: seq_op_width];
    d.ra      = inst[3*seq_rn_width-1 -: seq_rn_width];
    d.rb      = inst[2*seq_rn_width-1 -: seq_rn_width];
    d.rd_a    = 1'b0;
    d.rd_b    = 1'b0;
    d.wr      = 1'b0;
    d.is_send = 1'b0;
    d.wreg    = d.ra;
    case (op)
      seq_op_push: d.wr = 1'b1;
      seq_op_add, seq_op_mult: begin
        d.rd_a = 1'b1;
        d.rd_b = 1'b1;
        d.wr   = 1'b1;
        d.wreg = inst[seq_rn_width-1:0];
      end
      seq_op_send: begin
        d.rd_a    = 1'b1;
        d.is_send = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_issue_fifo.sv
// Synchronous FIFO with occupancy count and a flush that empties it in one edge.
// Pushes when full and pops when empty are ignored; flush overrides both.
module seq_issue_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/seq_issue.sv
// Instruction buffer and in-order issue controller for seq: stalls on register RAW hazards
// against the fixed ALU latency and paces SENDs against the UART transmitter.
module seq_issue
  import seq_issue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1,
  parameter int TX_GAP  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [seq_in_width-1:0]    i_inst,
  input  logic                       i_inst_valid,
  output logic                       o_inst_ready,
  output logic [seq_in_width-1:0]    o_inst,
  output logic                       o_inst_valid,
  input  logic                       i_tx_busy,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_stall
);

  localparam int CW = $clog2(ALU_LAT + 2);
  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  logic [seq_in_width-1:0] fifo_head;
  logic                    fifo_full, fifo_empty, fifo_push;
  seq_dec_t                dec;
  logic                    hazard, tx_ok, issue;

  logic [CW-1:0]           cnt_q [seq_nregs];
  logic [CW-1:0]           cnt_d [seq_nregs];
  logic [GW-1:0]           gap_q, gap_d;
  logic [seq_in_width-1:0] o_inst_q, o_inst_d;
  logic                    o_inst_valid_q, o_inst_valid_d;

  // Upstream handshake: a word transfers on any edge where i_inst_valid & o_inst_ready;
  // ready depends only on occupancy (not on this cycle's issue) and is low while in reset.
  assign o_inst_ready = ~fifo_full & ~rst;
  assign fifo_push    = i_inst_valid & o_inst_ready;

  seq_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (seq_in_width)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (issue),
    .flush (i_flush),
    .wdata (i_inst),
    .rdata (fifo_head),
    .level (o_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dec = seq_decode(fifo_head);

  // A count of 1 means the ALU result is written at this edge, so a reader issued now
  // reaches seq in time to see it; only counts above 1 block.
  always_comb begin
    hazard = 1'b0;
    if (dec.rd_a && (cnt_q[dec.ra] > CW'(1))) hazard = 1'b1;
    if (dec.rd_b && (cnt_q[dec.rb] > CW'(1))) hazard = 1'b1;
  end

  assign tx_ok   = ~dec.is_send | (~i_tx_busy & (gap_q == '0));
  assign issue   = ~fifo_empty & ~hazard & tx_ok & ~i_flush;
  assign o_stall = ~fifo_empty & ~issue;

  always_comb begin
    for (int r = 0; r < seq_nregs; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
    end
    if (issue && dec.wr) cnt_d[dec.wreg] = CW'(ALU_LAT + 1);

    gap_d = (gap_q != '0) ? gap_q - GW'(1) : '0;
    if (issue && dec.is_send) gap_d = GW'(TX_GAP - 1);

    o_inst_valid_d = issue;
    o_inst_d       = issue ? fifo_head : o_inst_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < seq_nregs; r++) cnt_q[r] <= '0;
      gap_q          <= '0;
      o_inst_q       <= '0;
      o_inst_valid_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      o_inst_q       <= o_inst_d;
      o_inst_valid_q <= o_inst_valid_d;
    end
  end

  assign o_inst       = o_inst_q;
  assign o_inst_valid = o_inst_valid_q;

endmodule

// File: tb/tb_seq_issue.sv
// Bench for seq_issue: directed vector table, hand-written corner sequences and random traffic,
// all checked against a queue-based model that works in issue-cycle numbers.
module tb_seq_issue;
  import seq_issue_pkg::*;

  localparam int W       = seq_in_width;
  localparam int RN      = seq_rn_width;
  localparam int RN2     = 2 * seq_rn_width;
  localparam int DEPTH   = 8;
  localparam int ALU_LAT = 1;
  localparam int TX_GAP  = 2;
  localparam int LW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  i_inst;
  logic          i_inst_valid;
  logic          o_inst_ready;
  logic [W-1:0]  o_inst;
  logic          o_inst_valid;
  logic          i_tx_busy;
  logic          i_flush;
  logic [LW-1:0] o_level;
  logic          o_stall;

  always #5 clk = ~clk;

  seq_issue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TX_GAP(TX_GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_inst       (i_inst),
    .i_inst_valid (i_inst_valid),
    .o_inst_ready (o_inst_ready),
    .o_inst       (o_inst),
    .o_inst_valid (o_inst_valid),
    .i_tx_busy    (i_tx_busy),
    .i_flush      (i_flush),
    .o_level      (o_level),
    .o_stall      (o_stall)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queued instructions, earliest legal issue cycle per register, last SEND cycle
  logic [W-1:0] exp_q[$];
  int           reg_ready [seq_nregs];
  int           last_send;
  int           cyc;
  logic         exp_v;
  logic [W-1:0] exp_inst;

  int           vcyc[$];
  logic [W-1:0] vinst[$];
  logic         obs_v, obs_stall, obs_ready;
  logic [LW-1:0] obs_level;
  logic [W-1:0] obs_inst;

  typedef struct {
    logic [W-1:0]  inst;
    logic          v;
    logic          exp_valid;
    logic [W-1:0]  exp_inst;
    logic          exp_stall;
    logic [LW-1:0] exp_level;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [W-1:0] mk(input logic [1:0] op, input int a, input int b, input int c);
    return {op, RN'(a), RN'(b), RN'(c)};
  endfunction

  function automatic logic [W-1:0] mkp(input int r, input int imm);
    return {seq_op_push, RN'(r), RN2'(imm)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    foreach (reg_ready[i]) reg_ready[i] = 0;
    last_send = -1000;
    exp_v     = 1'b0;
    exp_inst  = '0;
  endtask

  task automatic tick(input logic [W-1:0] inst, input logic v, input logic busy, input logic fl);
    logic         m_ready, m_issue, m_stall, m_push;
    logic [W-1:0] m_head;
    logic [1:0]   op;
    int           ra, rb, rc;
    @(negedge clk);
    i_inst       = inst;
    i_inst_valid = v;
    i_tx_busy    = busy;
    i_flush      = fl;
    #1;
    m_ready = (exp_q.size() != DEPTH);
    m_issue = 1'b0;
    m_head  = '0;
    op      = 2'd0;
    ra      = 0;
    rb      = 0;
    rc      = 0;
    if (exp_q.size() > 0 && !fl) begin
      m_head  = exp_q[0];
      m_issue = 1'b1;
      op      = m_head[W-1 -: 2];
      ra      = int'(m_head[3*RN-1 -: RN]);
      rb      = int'(m_head[2*RN-1 -: RN]);
      rc      = int'(m_head[RN-1:0]);
      if (op == seq_op_add || op == seq_op_mult) begin
        if (cyc + 1 < reg_ready[ra] || cyc + 1 < reg_ready[rb]) m_issue = 1'b0;
      end else if (op == seq_op_send) begin
        if (cyc + 1 < reg_ready[ra] || busy || cyc + 1 < last_send + TX_GAP) m_issue = 1'b0;
      end
    end
    m_stall = (exp_q.size() > 0) && !m_issue;
    m_push  = v && m_ready && !fl;

    obs_v     = o_inst_valid;
    obs_stall = o_stall;
    obs_ready = o_inst_ready;
    obs_level = o_level;
    obs_inst  = o_inst;
    chk("ready", obs_ready, m_ready);
    chk("stall", obs_stall, m_stall);
    chk("level", obs_level, exp_q.size());
    chk("valid", obs_v, exp_v);
    chk("inst", obs_inst, exp_inst);
    if (obs_v) begin
      vcyc.push_back(cyc);
      vinst.push_back(obs_inst);
    end

    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      exp_v = 1'b0;
    end else begin
      exp_v = m_issue;
      if (m_issue) begin
        void'(exp_q.pop_front());
        exp_inst = m_head;
        if (op == seq_op_push) reg_ready[ra] = cyc + 2 + ALU_LAT;
        if (op == seq_op_add || op == seq_op_mult) reg_ready[rc] = cyc + 2 + ALU_LAT;
        if (op == seq_op_send) last_send = cyc + 1;
      end
      if (m_push) exp_q.push_back(inst);
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic busy);
    for (int i = 0; i < n; i++) tick('0, 1'b0, busy, 1'b0);
  endtask

  initial begin
    int n, mark;
    rst = 1'b1;
    i_inst = '0;
    i_inst_valid = 1'b0;
    i_tx_busy = 1'b0;
    i_flush = 1'b0;
    cyc = 0;
    model_reset();

    tbl[0] = '{14'h0003, 1'b1, 1'b0, 14'h0000, 1'b0, 4'd0};
    tbl[1] = '{14'h0104, 1'b1, 1'b0, 14'h0000, 1'b0, 4'd1};
    tbl[2] = '{14'h0000, 1'b0, 1'b1, 14'h0003, 1'b0, 4'd1};
    tbl[3] = '{14'h0000, 1'b0, 1'b1, 14'h0104, 1'b0, 4'd0};
    tbl[4] = '{14'h0105, 1'b1, 1'b0, 14'h0000, 1'b0, 4'd0};
    tbl[5] = '{14'h3100, 1'b1, 1'b0, 14'h0000, 1'b0, 4'd1};
    tbl[6] = '{14'h0000, 1'b0, 1'b1, 14'h0105, 1'b1, 4'd1};
    tbl[7] = '{14'h0000, 1'b0, 1'b0, 14'h0000, 1'b0, 4'd1};
    tbl[8] = '{14'h0000, 1'b0, 1'b1, 14'h3100, 1'b0, 4'd0};
    tbl[9] = '{14'h0000, 1'b0, 1'b0, 14'h0000, 1'b0, 4'd0};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    tick('0, 1'b0, 1'b0, 1'b0);
    chk("rst_level", obs_level, 0);
    chk("rst_valid", obs_v, 0);
    chk("rst_inst", obs_inst, 0);
    chk("rst_ready", obs_ready, 1);
    chk("rst_stall", obs_stall, 0);
    idle(2, 1'b0);

    // back-to-back independent pushes, then RAW push r1 -> send r1
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].inst, tbl[i].v, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_valid", i), obs_v, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_stall", i), obs_stall, tbl[i].exp_stall);
      chk($sformatf("tbl%0d_level", i), obs_level, tbl[i].exp_level);
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_inst", i), obs_inst, tbl[i].exp_inst);
    end

    // asynchronous reset with five queued and an issue in flight
    for (int i = 0; i < 5; i++) tick(mk(seq_op_send, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    i_inst_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_level", o_level, 0);
    chk("midrst_valid", o_inst_valid, 0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc += 2;
    n = vcyc.size();
    idle(5, 1'b0);
    chk("midrst_no_issue", vcyc.size(), n);

    // SEND held by tx busy, released, then paced
    tick(mk(seq_op_send, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    n = vcyc.size();
    idle(10, 1'b1);
    chk("tx_busy_hold", vcyc.size(), n);
    tick('0, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    chk("tx_release", obs_v, 1);
    tick(mk(seq_op_send, 2, 0, 0), 1'b1, 1'b0, 1'b0);
    tick(mk(seq_op_send, 3, 0, 0), 1'b1, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("tx_gap", (vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2]) >= TX_GAP, 1);

    // fill to full, push+pop at full, drain 20 in order across wrap
    tick(mk(seq_op_send, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick(mkp(2, i), 1'b1, 1'b1, 1'b0);
    tick('0, 1'b0, 1'b1, 1'b0);
    chk("full_ready", obs_ready, 0);
    chk("full_level", obs_level, DEPTH);
    tick(mkp(2, 100), 1'b1, 1'b0, 1'b0);
    tick(mkp(2, 101), 1'b1, 1'b0, 1'b0);
    chk("pushpop_pre", obs_level, DEPTH - 1);
    tick(mkp(2, 102), 1'b1, 1'b0, 1'b0);
    chk("pushpop_hold", obs_level, DEPTH - 1);
    idle(12, 1'b0);
    mark = vinst.size();
    for (int i = 0; i < 20; i++) tick(mkp(3, 200 + i), 1'b1, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("drain_count", vinst.size() - mark, 20);
    for (int i = 0; i < 20 && mark + i < vinst.size(); i++)
      chk($sformatf("drain_order%0d", i), vinst[mark+i], mkp(3, 200 + i));

    // flush with a simultaneous enqueue
    for (int i = 0; i < 4; i++) tick(mk(seq_op_send, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    tick(mk(seq_op_send, 1, 0, 0), 1'b1, 1'b1, 1'b1);
    n = vcyc.size();
    tick('0, 1'b0, 1'b0, 1'b0);
    chk("flush_level", obs_level, 0);
    chk("flush_valid", obs_v, 0);
    idle(4, 1'b0);
    chk("flush_no_issue", vcyc.size(), n);
    tick(mkp(1, 9), 1'b1, 1'b0, 1'b0);
    tick(mk(seq_op_send, 1, 0, 0), 1'b1, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("raw_after_flush", vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2], ALU_LAT + 1);

    // random traffic with hazards, busy and flushes
    for (int i = 0; i < 1500; i++) begin
      tick(mk(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3)),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), ($urandom_range(0, 49) == 0));
    end
    idle(30, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
